temp_bcd_formatter: RTL

- Sits directly downstream of the I2C master that reads the ADT7420-class temperature sensor (device 0x4B, ID register 0x0B, temperature register 0x00).
- Consumes the byte stream the master produces on a read transaction.
- Temperature mode: assembles MSB/LSB into the 13-bit two's-complement reading (0.0625 °C/LSB) and converts it sequentially (double-dabble) to sign + 3 BCD integer digits + 1 BCD tenths digit for the display stage.
- ID mode: passes the single ID byte through with a valid pulse.

---
 rtl/temp_bcd_formatter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/temp_bcd_formatter.sv
// Turns the temperature sensor's read bytes into sign + BCD degrees + BCD tenths.
// In ID mode the single ID byte is passed straight through instead.
module temp_bcd_formatter #(
    parameter int INT_BITS = 9,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_mode,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  out_err,
    output logic                  out_is_id,
    output logic [7:0]            out_id,
    output logic                  out_sign,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            out_frac
);

    localparam int CW = $clog2(INT_BITS + 1);
    localparam int SW = 4*DIGITS + INT_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_LSB, S_CALC, S_CONV, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0]          r_raw;
    logic [INT_BITS-1:0]  r_int;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [CW-1:0]        r_cnt;
    logic                 r_sign;
    logic [3:0]           r_frac;

    logic w_id_accept, w_ld_msb, w_ld_lsb, w_calc, w_shift_en, w_done, w_err;

    logic [12:0]          w_t;
    logic [12:0]          w_mag;
    logic [7:0]           w_frac_prod;
    logic [4*DIGITS-1:0]  w_adj;
    logic [SW-1:0]        w_shift;

    // 13-bit reading; magnitude of the most negative code wraps to itself
    assign w_t         = r_raw[15:3];
    assign w_mag       = w_t[12] ? (~w_t + 13'd1) : w_t;
    assign w_frac_prod = {4'd0, w_mag[3:0]} * 8'd10;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = {w_adj, r_int} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (byte_valid && !id_mode && !byte_last) begin
                    w_next = S_GET_LSB;
                end
            end
            S_GET_LSB: begin
                if (byte_valid) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: w_next = S_CONV;
            S_CONV: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        w_id_accept = 1'b0;
        w_ld_msb    = 1'b0;
        w_ld_lsb    = 1'b0;
        w_calc      = 1'b0;
        w_shift_en  = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_id_accept = byte_valid && id_mode;
                w_ld_msb    = byte_valid && !id_mode && !byte_last;
                w_err       = byte_valid && !id_mode && byte_last;
            end
            S_GET_LSB: w_ld_lsb = byte_valid;
            S_CALC: begin
                w_calc = 1'b1;
                w_err  = byte_valid;
            end
            S_CONV: begin
                w_shift_en = 1'b1;
                w_err      = byte_valid;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_err  = byte_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw  <= '0;
            r_int  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_frac <= '0;
        end else begin
            if (w_ld_msb) r_raw[15:8] <= byte_data;
            if (w_ld_lsb) r_raw[7:0]  <= byte_data;
            if (w_calc) begin
                r_sign <= w_t[12];
                r_int  <= w_mag[12:4];
                r_frac <= w_frac_prod[7:4];
                r_bcd  <= '0;
                r_cnt  <= CW'(INT_BITS);
            end
            if (w_shift_en) begin
                r_bcd <= w_shift[SW-1 -: 4*DIGITS];
                r_int <= w_shift[INT_BITS-1:0];
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_is_id <= 1'b0;
            out_id    <= '0;
            out_sign  <= 1'b0;
            out_bcd   <= '0;
            out_frac  <= '0;
        end else begin
            out_valid <= w_done || w_id_accept;
            out_err   <= w_err;
            if (w_id_accept) begin
                out_id    <= byte_data;
                out_is_id <= 1'b1;
            end
            if (w_done) begin
                out_sign  <= r_sign;
                out_bcd   <= r_bcd;
                out_frac  <= r_frac;
                out_is_id <= 1'b0;
            end
        end
    end

endmodule
